// File: rtl/xrv_pkg.sv
// Shared types and widths for the xrv data-bus responder and its SRAM.
package xrv_pkg;

  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;
  localparam int CNT_W   = $clog2(16);

  typedef enum logic {OP_RD, OP_WR} bus_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} dmem_st_e;

endpackage

// File: rtl/xrv_sram_be.sv
// Single-port data SRAM with per-byte write enables and a registered read port.
module xrv_sram_be
  import xrv_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [BUS_BEW-1:0]             we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [BUS_DW-1:0]              wdata,
  output logic [BUS_DW-1:0]              q
);

  logic [BUS_DW-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BUS_BEW; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/xrv_dmem_rsp.sv
// Target end of the core data bus: wait-state insertion, window decode, sticky error.
//   state   | meaning
//   ST_IDLE | waiting for d_wr_req / d_rd_req; latches op and window flag
//   ST_WAIT | burning programmed wait cycles, cnt counts down to 1
//   ST_ACK  | one-cycle ready pulse; write commits at the closing edge
module xrv_dmem_rsp
  import xrv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_WAIT     = 0,
  parameter int          WR_WAIT     = 0
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [31:0]        d_addr,
  input  logic               d_wr_req,
  input  logic [BUS_BEW-1:0] d_be,
  input  logic [BUS_DW-1:0]  d_wr_data,
  output logic               d_wr_ready,
  input  logic               d_rd_req,
  output logic               d_rd_ready,
  output logic [BUS_DW-1:0]  d_rd_data,
  output logic               bus_err,
  output logic [31:0]        bus_err_addr,
  input  logic               bus_err_clr
);

  localparam int               AW      = $clog2(DEPTH_WORDS);
  localparam logic [32:0]      WIN_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] RD_W    = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_W    = CNT_W'(WR_WAIT);

  dmem_st_e         st_q, st_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  bus_op_e          op_q, op_nxt;
  logic             in_win_q, in_win_nxt;
  logic             in_win;
  logic             req_any;
  logic [CNT_W-1:0] wait_sel;
  logic             rd_ack_nxt, wr_ack_nxt, err_set;
  logic             sram_en;
  logic [BUS_BEW-1:0] sram_we;
  logic [AW-1:0]    sram_addr;
  logic [BUS_DW-1:0] sram_q;

  // 33-bit compare so a window ending exactly at 2^32 still decodes.
  assign in_win    = ({1'b0, d_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, d_addr} < WIN_END);
  assign sram_addr = AW'((d_addr - BASE_ADDR) >> 2);
  assign req_any   = d_wr_req | d_rd_req;
  assign wait_sel  = d_wr_req ? WR_W : RD_W;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_RD;
      in_win_q <= 1'b0;
    end else begin
      st_q     <= st_nxt;
      cnt_q    <= cnt_nxt;
      op_q     <= op_nxt;
      in_win_q <= in_win_nxt;
    end
  end

  always_comb begin
    st_nxt     = st_q;
    cnt_nxt    = cnt_q;
    op_nxt     = op_q;
    in_win_nxt = in_win_q;
    case (st_q)
      ST_IDLE: begin
        if (req_any) begin
          op_nxt     = d_wr_req ? OP_WR : OP_RD;
          in_win_nxt = in_win;
          if (wait_sel == '0) begin
            st_nxt = ST_ACK;
          end else begin
            st_nxt  = ST_WAIT;
            cnt_nxt = wait_sel;
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) st_nxt = ST_ACK;
      end
      ST_ACK:  st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Read is launched the cycle before ACK so the registered RAM output lines up with ready.
  always_comb begin
    rd_ack_nxt = (st_nxt == ST_ACK) && (op_nxt == OP_RD);
    wr_ack_nxt = (st_nxt == ST_ACK) && (op_nxt == OP_WR);
    err_set    = (st_q == ST_ACK) && !in_win_q;
    sram_en    = 1'b0;
    sram_we    = '0;
    if (rd_ack_nxt && in_win_nxt) sram_en = 1'b1;
    if ((st_q == ST_ACK) && (op_q == OP_WR) && in_win_q && rstb) begin
      sram_en = 1'b1;
      sram_we = d_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      d_rd_ready   <= 1'b0;
      d_wr_ready   <= 1'b0;
      bus_err      <= 1'b0;
      bus_err_addr <= '0;
    end else begin
      d_rd_ready <= rd_ack_nxt;
      d_wr_ready <= wr_ack_nxt;
      if (err_set) begin
        bus_err      <= 1'b1;
        bus_err_addr <= d_addr;
      end else if (bus_err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

  // RAM q is already a register; gating with registered flags keeps the bus at 0 outside ACK.
  assign d_rd_data = (d_rd_ready && in_win_q) ? sram_q : '0;

  xrv_sram_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (d_wr_data),
    .q     (sram_q)
  );

endmodule
